// File: rtl/alarm_field_setter_if.sv
// Handshake bundle for one alarm field: set-button controls and running time in,
// stored BCD digits, step pulse and match flag out.
interface alarm_field_setter_if;
  logic       BTN;
  logic       SEL_DOWN;
  logic       SET_ONES;
  logic       SET_TENS;
  logic [3:0] CUR_ONES;
  logic [3:0] CUR_TENS;
  logic       MATCH_EN;
  logic [3:0] COUNT_1;
  logic [3:0] COUNT_10;
  logic       STEP;
  logic       MATCH;

  modport master (
    output BTN, SEL_DOWN, SET_ONES, SET_TENS, CUR_ONES, CUR_TENS, MATCH_EN,
    input  COUNT_1, COUNT_10, STEP, MATCH
  );

  modport slave (
    input  BTN, SEL_DOWN, SET_ONES, SET_TENS, CUR_ONES, CUR_TENS, MATCH_EN,
    output COUNT_1, COUNT_10, STEP, MATCH
  );
endinterface

// File: rtl/alarm_field_setter.sv
// Two-digit BCD alarm field with per-digit up/down setting, modulus clamping,
// press-and-hold auto-repeat and a registered compare against running time.
module alarm_field_setter #(
  parameter int MODULUS      = 60,
  parameter int RESET_VALUE  = 0,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input logic                 CLK,
  input logic                 RESET,
  alarm_field_setter_if.slave bus
);

  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW      = $clog2(TMR_MAX) + 1;

  localparam logic [3:0]    TMAX      = 4'((MODULUS - 1) / 10);
  localparam logic [3:0]    RST_ONES  = 4'(RESET_VALUE % 10);
  localparam logic [3:0]    RST_TENS  = 4'(RESET_VALUE / 10);
  localparam logic [TW-1:0] DELAY_END = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_END  = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          btn_q, btn_d;
  logic [3:0]    count1_q, count1_d;
  logic [3:0]    count10_q, count10_d;
  logic          step_q, step_d;
  logic          match_q, match_d;

  logic          req;
  logic          apply;
  logic [3:0]    tens_nxt;
  logic [3:0]    ones_lim;

  // Largest legal ones digit for a given tens digit.
  function automatic logic [3:0] omax(input logic [3:0] tens);
    int v;
    v = MODULUS - 1 - 10 * int'(tens);
    if (v > 9) begin
      omax = 4'd9;
    end else if (v < 0) begin
      omax = 4'd0;
    end else begin
      omax = 4'(v);
    end
  endfunction

  // Auto-repeat sequencer: one request on press, then after DELAY, then every RATE.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.BTN && !btn_q) begin
          req     = 1'b1;
          timer_d = {TW{1'b0}};
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!bus.BTN) begin
          state_d = IDLE;
        end else if (timer_q == DELAY_END) begin
          req     = 1'b1;
          timer_d = {TW{1'b0}};
          state_d = RPT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RPT: begin
        if (!bus.BTN) begin
          state_d = IDLE;
        end else if (timer_q == RATE_END) begin
          req     = 1'b1;
          timer_d = {TW{1'b0}};
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = {TW{1'b0}};
      end
    endcase
  end

  // Digit update; a tens change pulls the ones digit down if it would exceed the modulus.
  always_comb begin
    btn_d     = bus.BTN;
    apply     = req && (bus.SET_ONES ^ bus.SET_TENS);
    count1_d  = count1_q;
    count10_d = count10_q;
    tens_nxt  = count10_q;
    ones_lim  = omax(count10_q);
    if (apply && bus.SET_ONES) begin
      if (!bus.SEL_DOWN) begin
        count1_d = (count1_q == ones_lim) ? 4'd0 : count1_q + 4'd1;
      end else begin
        count1_d = (count1_q == 4'd0) ? ones_lim : count1_q - 4'd1;
      end
    end else if (apply) begin
      if (!bus.SEL_DOWN) begin
        tens_nxt = (count10_q == TMAX) ? 4'd0 : count10_q + 4'd1;
      end else begin
        tens_nxt = (count10_q == 4'd0) ? TMAX : count10_q - 4'd1;
      end
      ones_lim  = omax(tens_nxt);
      count10_d = tens_nxt;
      count1_d  = (count1_q > ones_lim) ? ones_lim : count1_q;
    end else begin
      count1_d = count1_q;
    end
    step_d  = apply;
    match_d = bus.MATCH_EN && (bus.CUR_TENS == count10_q) && (bus.CUR_ONES == count1_q);
  end

  // State register; btn_q resets high so a button held through reset cannot step.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      timer_q   <= {TW{1'b0}};
      btn_q     <= 1'b1;
      count1_q  <= RST_ONES;
      count10_q <= RST_TENS;
      step_q    <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      btn_q     <= btn_d;
      count1_q  <= count1_d;
      count10_q <= count10_d;
      step_q    <= step_d;
      match_q   <= match_d;
    end
  end

  assign bus.COUNT_1  = count1_q;
  assign bus.COUNT_10 = count10_q;
  assign bus.STEP     = step_q;
  assign bus.MATCH    = match_q;

endmodule

// File: tb/tb_alarm_field_setter.sv
// Scoreboard bench: expected field values are queued at each press and checked
// whenever the DUT pulses STEP; explicit checks cover reset, no-step and match cases.
module tb_alarm_field_setter;

  logic clk;
  logic rst60;
  logic rst24;
  int   checks;
  int   errors;
  int   steps60;
  int   steps24;
  logic [7:0] q60[$];
  logic [7:0] q24[$];

  alarm_field_setter_if a60();
  alarm_field_setter_if a24();

  alarm_field_setter #(.MODULUS(60), .RESET_VALUE(0), .REPEAT_DELAY(5), .REPEAT_RATE(2)) u60 (
    .CLK(clk), .RESET(rst60), .bus(a60)
  );

  alarm_field_setter #(.MODULUS(24), .RESET_VALUE(23), .REPEAT_DELAY(5), .REPEAT_RATE(2)) u24 (
    .CLK(clk), .RESET(rst24), .bus(a24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop for the MODULUS=60 field.
  always @(negedge clk) begin
    if (!rst60 && a60.STEP) begin
      steps60++;
      if (q60.size() == 0) begin
        check_val("spurious_step60", int'(a60.STEP), 0);
      end else begin
        check_val("step60_value", int'({a60.COUNT_10, a60.COUNT_1}), int'(q60.pop_front()));
      end
    end
  end

  // Scoreboard pop for the MODULUS=24 field.
  always @(negedge clk) begin
    if (!rst24 && a24.STEP) begin
      steps24++;
      if (q24.size() == 0) begin
        check_val("spurious_step24", int'(a24.STEP), 0);
      end else begin
        check_val("step24_value", int'({a24.COUNT_10, a24.COUNT_1}), int'(q24.pop_front()));
      end
    end
  end

  task automatic press24(input logic ones, input logic down, input logic [7:0] exp);
    a24.SET_ONES = ones;
    a24.SET_TENS = ~ones;
    a24.SEL_DOWN = down;
    q24.push_back(exp);
    a24.BTN = 1'b1;
    @(posedge clk); #1;
    a24.BTN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press60(input logic ones, input logic down, input logic [7:0] exp);
    a60.SET_ONES = ones;
    a60.SET_TENS = ~ones;
    a60.SEL_DOWN = down;
    q60.push_back(exp);
    a60.BTN = 1'b1;
    @(posedge clk); #1;
    a60.BTN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    checks  = 0;
    errors  = 0;
    steps60 = 0;
    steps24 = 0;
    {a60.BTN, a60.SEL_DOWN, a60.SET_ONES, a60.SET_TENS, a60.MATCH_EN} = 5'b00000;
    {a24.BTN, a24.SEL_DOWN, a24.SET_ONES, a24.SET_TENS, a24.MATCH_EN} = 5'b00000;
    a60.CUR_ONES = 4'd0; a60.CUR_TENS = 4'd0;
    a24.CUR_ONES = 4'd0; a24.CUR_TENS = 4'd0;

    // Reset with the button held on the 60 field
    a60.BTN = 1'b1;
    a60.SET_ONES = 1'b1;
    rst60 = 1'b1;
    rst24 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst60_value", int'({a60.COUNT_10, a60.COUNT_1}), 'h00);
    check_val("rst60_step", int'(a60.STEP), 0);
    check_val("rst60_match", int'(a60.MATCH), 0);
    check_val("rst24_value", int'({a24.COUNT_10, a24.COUNT_1}), 'h23);
    rst60 = 1'b0;
    rst24 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("held_through_reset_steps", steps60, 0);
    check_val("held_through_reset_value", int'({a60.COUNT_10, a60.COUNT_1}), 'h00);
    @(posedge clk); #1;
    a60.BTN = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ones wrap / tens clamp on MODULUS=24, starting from 23
    press24(1'b1, 1'b0, 8'h20);
    press24(1'b1, 1'b1, 8'h23);
    press24(1'b0, 1'b1, 8'h13);
    press24(1'b1, 1'b0, 8'h14);
    press24(1'b1, 1'b0, 8'h15);
    press24(1'b1, 1'b0, 8'h16);
    press24(1'b1, 1'b0, 8'h17);
    press24(1'b1, 1'b0, 8'h18);
    press24(1'b1, 1'b0, 8'h19);
    press24(1'b0, 1'b0, 8'h23);
    press24(1'b0, 1'b0, 8'h03);
    press24(1'b0, 1'b1, 8'h23);

    // MODULUS=60: reach 59, tens up clamps to 09, ones up wraps to 00
    press60(1'b0, 1'b1, 8'h50);
    press60(1'b1, 1'b1, 8'h59);
    press60(1'b0, 1'b0, 8'h09);
    press60(1'b1, 1'b0, 8'h00);

    // Auto-repeat: 12 held edges give steps at k, k+5, k+7, k+9, k+11
    base = steps60;
    a60.SET_ONES = 1'b1; a60.SET_TENS = 1'b0; a60.SEL_DOWN = 1'b0;
    q60.push_back(8'h01); q60.push_back(8'h02); q60.push_back(8'h03);
    q60.push_back(8'h04); q60.push_back(8'h05);
    a60.BTN = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    a60.BTN = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("repeat_step_count", steps60 - base, 5);
    check_val("repeat_final_value", int'({a60.COUNT_10, a60.COUNT_1}), 'h05);

    // Both selects high: request swallowed
    base = steps60;
    a60.SET_ONES = 1'b1; a60.SET_TENS = 1'b1;
    a60.BTN = 1'b1;
    @(posedge clk); #1;
    a60.BTN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("illegal_sel_steps", steps60 - base, 0);
    check_val("illegal_sel_value", int'({a60.COUNT_10, a60.COUNT_1}), 'h05);

    // Release on the edge where the HOLD timer would expire
    base = steps60;
    a60.SET_TENS = 1'b0;
    q60.push_back(8'h06);
    a60.BTN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    a60.BTN = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_val("release_at_expiry_steps", steps60 - base, 1);
    check_val("release_at_expiry_value", int'({a60.COUNT_10, a60.COUNT_1}), 'h06);

    // Match compare
    press60(1'b1, 1'b0, 8'h07);
    a60.CUR_TENS = 4'd0; a60.CUR_ONES = 4'd7; a60.MATCH_EN = 1'b1;
    @(negedge clk);
    check_val("match_lag", int'(a60.MATCH), 0);
    @(posedge clk); @(negedge clk);
    check_val("match_hit", int'(a60.MATCH), 1);
    a60.MATCH_EN = 1'b0;
    @(posedge clk); @(negedge clk);
    check_val("match_disarmed", int'(a60.MATCH), 0);
    a60.MATCH_EN = 1'b1; a60.CUR_ONES = 4'd8;
    @(posedge clk); @(negedge clk);
    check_val("match_cur_differs", int'(a60.MATCH), 0);
    a60.CUR_ONES = 4'd7;
    @(posedge clk); @(negedge clk);
    check_val("match_rehit", int'(a60.MATCH), 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("q60_drained", q60.size(), 0);
    check_val("q24_drained", q24.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_field_setter.md
# alarm_field_setter

Parametrised two-digit BCD alarm-field register for the 24-hour clock, one instance per alarm field (minutes MODULUS=60, hours MODULUS=24). It supports ones- and tens-digit setting with up/down direction and legal-value clamping for any modulus. It generates its own press-and-hold auto-repeat from a level button, and it compares the stored field against the running time digits to produce a registered match flag for the alarm logic.

## Interface
Parameters:
- MODULUS, 60, field range is 0..MODULUS-1; legal 2..99
- RESET_VALUE, 0, field value after reset; must be < MODULUS
- REPEAT_DELAY, 500, cycles from first step to first auto-repeat step; ≥1
- REPEAT_RATE, 100, cycles between subsequent auto-repeat steps; ≥1

Ports:
- CLK  in  1  rising-edge clock, single clock domain
- RESET  in  1  synchronous, active-high reset
- BTN  in  1  debounced set button, level; high = pressed
- SEL_DOWN  in  1  0 = step up, 1 = step down; sampled at each step
- SET_ONES  in  1  select ones digit for stepping
- SET_TENS  in  1  select tens digit for stepping
- CUR_ONES  in  4  running-time ones digit, BCD
- CUR_TENS  in  4  running-time tens digit, BCD
- MATCH_EN  in  1  alarm armed
- COUNT_1  out  4  stored ones digit, BCD
- COUNT_10  out  4  stored tens digit, BCD
- STEP  out  1  one-cycle pulse on each cycle a step is applied
- MATCH  out  1  registered compare result

## Operation
Notation: V = 10·COUNT_10 + COUNT_1, TMAX = (MODULUS-1)/10 (integer), OMAX(t) = min(9, MODULUS-1-10·t).
- Step request, FSM, states IDLE / HOLD / RPT; internal BTN_Q = BTN delayed one cycle; timer width clog2(max(REPEAT_DELAY, REPEAT_RATE))+1.
  - IDLE: BTN=1 and BTN_Q=0 → request step, timer←0, go HOLD.
  - HOLD: BTN=0 → IDLE. Timer = REPEAT_DELAY-1 → request step, timer←0, go RPT. Otherwise timer+1.
  - RPT: BTN=0 → IDLE. Timer = REPEAT_RATE-1 → request step, timer←0. Otherwise timer+1.
- A requested step is applied only if exactly one of SET_ONES/SET_TENS is high. If both or neither is high, no change and no STEP, but the FSM still advances.
- Ones step:
  - Up: COUNT_1 = OMAX(COUNT_10) → 0, else +1.
  - Down: 0 → OMAX(COUNT_10), else −1.
  - COUNT_10 is unchanged; no carry into tens.
- Tens step:
  - Up: COUNT_10 = TMAX → 0, else +1.
  - Down: 0 → TMAX, else −1.
  - After the tens update, if COUNT_1 > OMAX(new tens), COUNT_1 ← OMAX(new tens) on the same edge. Example: MODULUS=24, 19 tens-up → 23.
- Invariant: V < MODULUS at all times; both digits always valid BCD.
- STEP = 1 on the cycle after each edge at which a step was applied.
- MATCH ← MATCH_EN & (CUR_TENS==COUNT_10) & (CUR_ONES==COUNT_1), registered every cycle.
- Reset (synchronous, highest priority):
  - COUNT_10/COUNT_1 ← digits of RESET_VALUE.
  - FSM ← IDLE, timer ← 0, STEP ← 0, MATCH ← 0.
  - BTN_Q ← 1, so a button held through reset must be released and re-pressed before it steps.
  - Reset mid-HOLD/RPT aborts the repeat sequence.

## Timing
- Press latency: BTN sampled high at edge k (BTN_Q=0) → new COUNT visible after edge k; STEP high for cycle k..k+1.
- Held button: steps at edges k, k+REPEAT_DELAY, k+REPEAT_DELAY+REPEAT_RATE, k+REPEAT_DELAY+2·REPEAT_RATE, …
- Release: BTN sampled low at any edge in HOLD/RPT → IDLE at that edge, no step at that edge even if the timer expires simultaneously.
- REPEAT_DELAY=1 or REPEAT_RATE=1 is legal: a step is requested on every cycle while in the corresponding state.
- SEL_DOWN, SET_ONES and SET_TENS are sampled on the stepping edge only. A change mid-hold affects subsequent steps.
- MATCH lags the inputs by one cycle. A change to COUNT_* is reflected in MATCH one cycle after COUNT updates.

## Test plan
- Reset, MODULUS=60, RESET_VALUE=0: assert RESET 2 cycles → COUNT_10=0, COUNT_1=0, STEP=0, MATCH=0. Hold BTN=1 through reset release → no step until BTN drops and rises again.
- Ones wrap, MODULUS=24, value 23: SET_ONES, up press → 20. Down press from 20 → 23. Value 15, ones up → 16.
- Tens clamp, MODULUS=24, value 19: SET_TENS up → 23. Up again → 03. Down from 03 → 23. MODULUS=60, 59 tens up → 09.
- Auto-repeat, REPEAT_DELAY=5, REPEAT_RATE=2, MODULUS=60, value 00, SET_ONES up: hold BTN 12 cycles → steps at edges k, k+5, k+7, k+9, k+11, final value 05. Release → no further steps.
- Illegal select: SET_ONES=SET_TENS=1 with press → value unchanged, STEP stays 0. Release mid-HOLD coincident with timer expiry → no step.
- Match: value 07, MATCH_EN=1, drive CUR=07 → MATCH=1 one cycle later. MATCH_EN=0 → MATCH=0 next cycle. CUR=08 → MATCH=0.
